led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_sequencer.sv | 135 +++++++++++++
 tb/tb_led_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes,
// bounce direction and the speed-select width.
package led_seq_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step timer: counts to (PERIOD >> speed) - 1 and flags a step.
// clear restarts the count and suppresses the step; pause holds it.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int PERIOD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    output logic               tick
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] count;
    logic [CW-1:0] limit_m1;
    logic          terminal;

    assign limit_m1 = CW'((PERIOD >> speed) - 1);

    // >= rather than == so a lowered limit steps at once
    assign terminal = (count >= limit_m1);
    assign tick     = terminal & ~pause & ~clear;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (pause) begin
            count <= count;
        end else if (terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate, bounce and binary-count modes.
// Define LED_SEQ_PWM_EN to add the bright input and PWM dimming.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS   = 6,
    parameter int CLK_HZ     = 27_000_000,
    parameter int STEP_HZ    = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                pause,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]          bright,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic                step_pulse
);

    localparam int PERIOD = CLK_HZ / STEP_HZ;

    localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);

    localparam logic [NUM_LEDS-1:0] LED_RST =
        (ACTIVE_LOW != 0) ? ~ONE : ONE;

    mode_e               mode_in;
    mode_e               mode_q;
    dir_e                dir;
    dir_e                dir_d;
    dir_e                step_dir;
    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] pattern_d;
    logic [NUM_LEDS-1:0] step_pat;
    logic [NUM_LEDS-1:0] lit_d;
    logic [NUM_LEDS-1:0] led_d;
    logic                mode_chg;
    logic                tick;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);

    led_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mode_chg),
        .speed  (speed),
        .pause  (pause),
        .tick   (tick)
    );

    always_comb begin
        step_pat = pattern;
        step_dir = dir;
        unique case (mode_q)
            MODE_ROL: begin
                step_pat = {pattern[NUM_LEDS-2:0],
                            pattern[NUM_LEDS-1]};
            end
            MODE_ROR: begin
                step_pat = {pattern[0],
                            pattern[NUM_LEDS-1:1]};
            end
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    step_pat = pattern << 1;
                    if (step_pat[NUM_LEDS-1]) begin
                        step_dir = DIR_DOWN;
                    end
                end else begin
                    step_pat = pattern >> 1;
                    if (step_pat[0]) begin
                        step_dir = DIR_UP;
                    end
                end
            end
            MODE_COUNT: begin
                step_pat = pattern + ONE;
            end
        endcase
    end

    // Mode reload outranks both a pending step and pause
    always_comb begin
        pattern_d = pattern;
        dir_d     = dir;
        if (mode_chg) begin
            pattern_d = ONE;
            dir_d     = DIR_UP;
        end else if (tick) begin
            pattern_d = step_pat;
            dir_d     = step_dir;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign lit_d = (pwm_cnt <= bright) ? pattern_d : '0;
`else
    assign lit_d = pattern_d;
`endif

    assign led_d = (ACTIVE_LOW != 0) ? ~lit_d : lit_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= mode_in;
            pattern    <= ONE;
            dir        <= DIR_UP;
            step_pulse <= 1'b0;
            led        <= LED_RST;
        end else begin
            mode_q     <= mode_in;
            pattern    <= pattern_d;
            dir        <= dir_d;
            step_pulse <= tick;
            led        <= led_d;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed checks plus random stimulus
// compared every cycle against a step-count based model.
module tb_led_sequencer;

    localparam int N   = 6;
    localparam int AL  = 0;
    localparam int PER = 8;

    typedef struct {
        int         cnt;
        int         s;
        logic [1:0] mq;
        bit         sp;
        int         pwm;
    } mstate_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [1:0]   speed = 2'd0;
    logic         pause = 1'b0;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]   bright = 4'd15;
`endif
    logic [N-1:0] led;
    logic         step_pulse;

    int vectors = 0;
    int miscompares = 0;

    mstate_t      m = '{0, 0, 2'd0, 1'b0, 0};
    logic [N-1:0] m_led = '0;
    bit           m_valid = 1'b0;

    always #5 clk = ~clk;

    led_sequencer #(
        .NUM_LEDS   (N),
        .CLK_HZ     (8),
        .STEP_HZ    (1),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
`ifdef LED_SEQ_PWM_EN
        .bright     (bright),
`endif
        .led        (led),
        .step_pulse (step_pulse)
    );

    // Pattern as a function of the mode and steps since reload
    function automatic int pat_of(logic [1:0] mq, int s);
        int ph;
        case (mq)
            2'd0: return 1 << (s % N);
            2'd1: return 1 << ((N - s % N) % N);
            2'd2: begin
                ph = s % (2 * N - 2);
                return 1 << ((ph < N) ? ph : (2 * N - 2 - ph));
            end
            default: return (1 + s) % (1 << N);
        endcase
    endfunction

    function automatic logic [N-1:0] pol(int p);
        logic [N-1:0] v;
        v = N'(p);
        return (AL != 0) ? ~v : v;
    endfunction

    function automatic mstate_t mnext(mstate_t c, logic rn,
                                      logic [1:0] md,
                                      logic [1:0] sp,
                                      logic ps);
        mstate_t n;
        n = c;
        n.sp = 1'b0;
        n.pwm = (c.pwm + 1) % 16;
        if (!rn) begin
            n.cnt = 0;
            n.s = 0;
            n.mq = md;
            n.pwm = 0;
        end else if (md != c.mq) begin
            n.mq = md;
            n.s = 0;
            n.cnt = 0;
        end else if (!ps) begin
            if (c.cnt >= (PER >> sp) - 1) begin
                n.cnt = 0;
                n.s = c.s + 1;
                n.sp = 1'b1;
            end else begin
                n.cnt = c.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] mled(mstate_t c, logic rn,
                                          logic [1:0] md,
                                          logic [1:0] sp,
                                          logic ps);
        mstate_t n;
        int lit;
        if (!rn) return pol(1);
        n = mnext(c, rn, md, sp, ps);
        lit = pat_of(n.mq, n.s);
`ifdef LED_SEQ_PWM_EN
        if (c.pwm > int'(bright)) lit = 0;
`endif
        return pol(lit);
    endfunction

    always @(posedge clk) begin
        m_valid <= m_valid | ~rst_n;
        m       <= mnext(m, rst_n, mode, speed, pause);
        m_led   <= mled(m, rst_n, mode, speed, pause);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (led !== m_led || step_pulse !== m.sp) begin
                miscompares++;
                $display("FAIL model t=%0t led=%b sp=%b want led=%b sp=%b",
                         $time, led, step_pulse, m_led, m.sp);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0d want=%0d",
                     nm, $time, got, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_step(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (step_pulse !== 1'b1 && gap < 40);
        if (step_pulse !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL step_timeout t=%0t got=%b want=1",
                     $time, step_pulse);
        end
    endtask

    initial begin
        int g;
        int pulses;
        int r;
        int bseq [12];
        bseq = '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2, 4};

        rst_n = 1'b0;
        cyc(3);
        chk("reset_led", led, pol(1));
        chk("reset_sp", step_pulse, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 6; i++) begin
            wait_step(g);
            chk("rol_led", led, pol(1 << (i % 6)));
            chk("rol_gap", g, 8);
        end

        mode = 2'd2;
        cyc(1);
        chk("bnc_reload_led", led, pol(1));
        chk("bnc_reload_sp", step_pulse, 0);
        for (int i = 0; i < 12; i++) begin
            wait_step(g);
            chk("bnc_led", led, pol(bseq[i]));
            chk("bnc_gap", g, 8);
        end

        rst_n = 1'b0;
        mode = 2'd3;
        cyc(2);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            pulses += int'(step_pulse);
            if (i == 255) chk("cnt_mid", led, pol(33));
            if (i == 503) chk("cnt_wrap", led, pol(0));
        end
        chk("cnt_pulses", pulses, 64);
        chk("cnt_end", led, pol(1));

        mode = 2'd0;
        cyc(1);
        chk("spd_reload", led, pol(1));
        cyc(6);
        speed = 2'd2;
        cyc(1);
        chk("spd_first_sp", step_pulse, 1);
        chk("spd_first_led", led, pol(2));
        cyc(1);
        chk("spd_gap_sp", step_pulse, 0);
        cyc(1);
        chk("spd_second_sp", step_pulse, 1);
        chk("spd_second_led", led, pol(4));

        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("pause_led", led, pol(4));
            chk("pause_sp", step_pulse, 0);
        end
        pause = 1'b0;
        cyc(1);
        chk("resume_sp0", step_pulse, 0);
        cyc(1);
        chk("resume_sp1", step_pulse, 1);
        chk("resume_led", led, pol(8));
        speed = 2'd0;

        mode = 2'd3;
        cyc(1);
        mode = 2'd0;
        cyc(1);
        chk("mc_reload", led, pol(1));
        for (int i = 1; i <= 3; i++) begin
            wait_step(g);
            chk("mc_rol_led", led, pol(1 << i));
        end
        cyc(7);
        mode = 2'd1;
        cyc(1);
        chk("mc_led", led, pol(1));
        chk("mc_sp", step_pulse, 0);
        wait_step(g);
        chk("mc_ror_led", led, pol(32));
        chk("mc_ror_gap", g, 8);

`ifdef LED_SEQ_PWM_EN
        pause = 1'b1;
        bright = 4'd3;
        cyc(2);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            pulses += int'(led[5] ^ (AL != 0));
        end
        chk("pwm_b3", pulses, 8);
        bright = 4'd15;
        cyc(2);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            pulses += int'(led[5] ^ (AL != 0));
        end
        chk("pwm_b15", pulses, 32);
        pause = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 4) mode = 2'($urandom_range(0, 3));
            else if (r < 40) speed = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 99) < 8);
            rst_n = !($urandom_range(0, 999) < 2);
`ifdef LED_SEQ_PWM_EN
            if (r >= 980) bright = 4'($urandom_range(0, 15));
`endif
            cyc(1);
        end

        rst_n = 1'b1;
        pause = 1'b0;
        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
